// File: rtl/compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compositor_pkg
//  Description : Shared constants and types for arrow_frame_compositor.
//                Holds the lane-to-arrow code table, rating encodings, the
//                palette colours of the rating panel and the decode record
//                that travels down the ROM-latency delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
package compositor_pkg;

    // Arrow codes as they appear in the game-state array, in lane order.
    // Entries past the fifth lane use codes the game never emits, so an
    // extra lane can only match if the game is extended to produce them.
    localparam logic [2:0] LANE_CODE [0:7] = '{
        3'b110,     // shake
        3'b010,     // left
        3'b001,     // up
        3'b011,     // down
        3'b100,     // right
        3'b101,
        3'b111,
        3'b111
    };

    typedef enum logic [1:0] {
        RATING_NONE      = 2'b00,
        RATING_BAD       = 2'b01,
        RATING_GOOD      = 2'b10,
        RATING_EXCELLENT = 2'b11
    } rating_t;

    localparam logic [7:0] COLOUR_EXCELLENT = 8'hDA;
    localparam logic [7:0] COLOUR_GOOD      = 8'hDB;
    localparam logic [7:0] COLOUR_BAD       = 8'hD9;
    localparam logic [7:0] COLOUR_DEFAULT   = 8'hDC;

    // Per-pixel decode carried alongside the ROM access.
    typedef struct packed {
        logic       valid;
        logic       indicator;
        logic       hit;
        logic [2:0] lane;
        logic [7:0] colour;
    } decode_t;

    function automatic logic [7:0] rating_colour(input logic [1:0] rating);
        logic [7:0] colour;
        case (rating)
            RATING_EXCELLENT: colour = COLOUR_EXCELLENT;
            RATING_GOOD:      colour = COLOUR_GOOD;
            RATING_BAD:       colour = COLOUR_BAD;
            default:          colour = COLOUR_DEFAULT;
        endcase
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rating_hold.sv
`default_nettype none
// ============================================================================
//  Module      : rating_hold
//  Description : Per-player rating snapshot and hold timer. At each frame
//                snapshot a nonzero rating is captured and held for
//                HOLD_FRAMES frames; a zero rating lets the timer run down.
//                Drives the palette colour for the indicator panel.
//  Ports       : clock, resetn   - pixel clock, async active-low reset
//                snapshot        - frame snapshot strobe (pixel (0,0))
//                rating          - live rating from the game processor
//                colour          - panel colour for the displayed rating
//  Revision    : 1.0 - initial release
// ============================================================================
module rating_hold
    import compositor_pkg::*;
#(
    parameter int HOLD_FRAMES = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       snapshot,
    input  logic [1:0] rating,
    output logic [7:0] colour
);

    localparam int CW = $clog2(HOLD_FRAMES + 2);

    logic [CW-1:0] hold_cnt;
    logic [1:0]    hold_rating;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_cnt    <= '0;
            hold_rating <= RATING_NONE;
        end else if (snapshot) begin
            if (rating != RATING_NONE) begin
                hold_rating <= rating;
                hold_cnt    <= CW'(HOLD_FRAMES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

    assign colour = rating_colour((hold_cnt != '0) ? hold_rating : RATING_NONE);

endmodule
`default_nettype wire

// File: rtl/arrow_frame_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : arrow_frame_compositor
//  Description : Pipelined palette-index generator for the dance-game screen.
//                Tracks the raster position with counters, snapshots game
//                state at pixel (0,0), composites scrolling arrow sprites for
//                every player/lane over the background and renders the
//                rating panel at the bottom of the screen.
//  Ports       : clock, resetn          - pixel clock, async active-low reset
//                pixel_valid, frame_sync - pixel accept / frame restart
//                arrow_array, indicator - game state (snapshotted per frame)
//                bg_addr, bg_data       - background ROM port
//                sprite_addr, sprite_data - shared sprite ROM port, per lane
//                index, index_valid     - palette index out, 2+ROM_LATENCY
//                                         cycles after accept
//  Revision    : 1.0 - initial release
// ============================================================================
module arrow_frame_compositor
    import compositor_pkg::*;
#(
    parameter int         H_ACTIVE         = 640,
    parameter int         V_ACTIVE         = 480,
    parameter int         NUM_PLAYERS      = 2,
    parameter int         NUM_LANES        = 5,
    parameter int         LANE_WIDTH       = 64,
    parameter int         SPRITE_HEIGHT    = 64,
    parameter int         STATE_HEIGHT     = 16,
    parameter int         NUM_STATES       = 26,
    parameter int         INDICATOR_HEIGHT = 48,
    parameter int         ROM_LATENCY      = 1,
    parameter int         HOLD_FRAMES      = 30,
    parameter logic [7:0] TRANSPARENT      = 8'h00
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                pixel_valid,
    input  logic                                frame_sync,
    input  logic [NUM_PLAYERS*NUM_STATES*3-1:0] arrow_array,
    input  logic [NUM_PLAYERS*2-1:0]            indicator,
    output logic [18:0]                         bg_addr,
    output logic [11:0]                         sprite_addr,
    input  logic [NUM_LANES*8-1:0]              sprite_data,
    input  logic [7:0]                          bg_data,
    output logic [7:0]                          index,
    output logic                                index_valid
);

    localparam int PANEL_W    = H_ACTIVE / NUM_PLAYERS;
    localparam int XW         = $clog2(H_ACTIVE);
    localparam int YW         = $clog2(V_ACTIVE);
    localparam int PLW        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int RW         = $clog2(STATE_HEIGHT + 1);
    localparam int SW         = $clog2(V_ACTIVE / STATE_HEIGHT + 2);
    localparam int NUM_CAND   = SPRITE_HEIGHT / STATE_HEIGHT;
    localparam int ARROW_ROWS = V_ACTIVE - INDICATOR_HEIGHT;
    localparam int AW         = NUM_PLAYERS * NUM_STATES * 3;

    // ------------------------------------------------------------------
    // Raster counters. They always hold the position of the next pixel;
    // frame_sync overrides that position with (0,0) for the current cycle.
    // ------------------------------------------------------------------
    logic [XW-1:0] x_cnt,    cur_x,    nxt_x;
    logic [YW-1:0] y_cnt,    cur_y,    nxt_y;
    logic [18:0]   addr_cnt, cur_addr, nxt_addr;
    logic [RW-1:0] row_cnt,  cur_row,  nxt_row;
    logic [SW-1:0] slot_cnt, cur_slot, nxt_slot;
    logic          line_end, frame_end, at_origin, take_snapshot;

    always_comb begin
        cur_x    = frame_sync ? '0 : x_cnt;
        cur_y    = frame_sync ? '0 : y_cnt;
        cur_addr = frame_sync ? '0 : addr_cnt;
        cur_row  = frame_sync ? '0 : row_cnt;
        cur_slot = frame_sync ? '0 : slot_cnt;

        line_end  = (cur_x == XW'(H_ACTIVE - 1));
        frame_end = line_end && (cur_y == YW'(V_ACTIVE - 1));
        at_origin = (cur_x == '0) && (cur_y == '0);

        nxt_x    = line_end ? '0 : cur_x + XW'(1);
        nxt_y    = cur_y;
        nxt_row  = cur_row;
        nxt_slot = cur_slot;
        nxt_addr = cur_addr + 19'd1;
        if (frame_end) begin
            nxt_y    = '0;
            nxt_row  = '0;
            nxt_slot = '0;
            nxt_addr = '0;
        end else if (line_end) begin
            nxt_y = cur_y + YW'(1);
            if (cur_row == RW'(STATE_HEIGHT - 1)) begin
                nxt_row  = '0;
                nxt_slot = cur_slot + SW'(1);
            end else begin
                nxt_row = cur_row + RW'(1);
            end
        end
    end

    assign take_snapshot = pixel_valid && at_origin;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
            row_cnt  <= '0;
            slot_cnt <= '0;
        end else if (pixel_valid) begin
            x_cnt    <= nxt_x;
            y_cnt    <= nxt_y;
            addr_cnt <= nxt_addr;
            row_cnt  <= nxt_row;
            slot_cnt <= nxt_slot;
        end else if (frame_sync) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
            row_cnt  <= '0;
            slot_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot of the arrow state and per-player rating hold.
    // ------------------------------------------------------------------
    logic [AW-1:0]            snap_arrows;
    logic [NUM_PLAYERS*8-1:0] colour_bus;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap_arrows <= '0;
        end else if (take_snapshot) begin
            snap_arrows <= arrow_array;
        end
    end

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_players
            rating_hold #(
                .HOLD_FRAMES (HOLD_FRAMES)
            ) u_rating_hold (
                .clock    (clock),
                .resetn   (resetn),
                .snapshot (take_snapshot),
                .rating   (indicator[2*g +: 2]),
                .colour   (colour_bus[8*g +: 8])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Region decode: player and lane by comparator chains on x.
    // ------------------------------------------------------------------
    logic [PLW-1:0] player;
    logic [XW-1:0]  local_x, col;
    logic [2:0]     lane;

    always_comb begin
        player  = '0;
        local_x = cur_x;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (cur_x >= XW'(p * PANEL_W)) begin
                player  = PLW'(p);
                local_x = cur_x - XW'(p * PANEL_W);
            end
        end
        lane = '0;
        col  = local_x;
        for (int l = 1; l < NUM_LANES; l++) begin
            if (local_x >= XW'(l * LANE_WIDTH)) begin
                lane = 3'(l);
                col  = local_x - XW'(l * LANE_WIDTH);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arrow hit search. Candidate k looks at state slot n-k; scanning from
    // the top candidate down lets the lowest hitting k win. Pixel (0,0)
    // takes its state straight from the port, since the snapshot register
    // only loads on that same edge.
    // ------------------------------------------------------------------
    logic [AW-1:0] arrows_eff;
    logic          hit, in_ind;
    int            hit_k, slot_idx, sel_idx, sprite_row;
    logic [11:0]   sprite_nxt;

    always_comb begin
        arrows_eff = at_origin ? arrow_array : snap_arrows;
        hit        = 1'b0;
        hit_k      = 0;
        slot_idx   = 0;
        sel_idx    = 0;
        for (int k = NUM_CAND - 1; k >= 0; k--) begin
            slot_idx = int'(cur_slot) - k;
            if (slot_idx >= 0 && slot_idx < NUM_STATES) begin
                sel_idx = int'(player) * NUM_STATES + slot_idx;
                if (arrows_eff[3*sel_idx +: 3] == LANE_CODE[lane]) begin
                    hit   = 1'b1;
                    hit_k = k;
                end
            end
        end
        in_ind     = (int'(cur_y) >= ARROW_ROWS);
        // y - STATE_HEIGHT*(n-k) reduces to k*STATE_HEIGHT + row-in-slot.
        sprite_row = hit_k * STATE_HEIGHT + int'(cur_row);
        sprite_nxt = 12'(sprite_row * LANE_WIDTH + int'(col));
    end

    // ------------------------------------------------------------------
    // Stage 1 and the ROM-latency delay line.
    // ------------------------------------------------------------------
    decode_t pipe [0:ROM_LATENCY];
    decode_t s1_nxt;
    decode_t out_d;

    always_comb begin
        s1_nxt.valid     = pixel_valid;
        s1_nxt.indicator = in_ind;
        s1_nxt.hit       = hit && !in_ind;
        s1_nxt.lane      = lane;
        // Panel colour is captured now: the hold state may advance on the
        // very next pixel if it is the next frame's (0,0).
        s1_nxt.colour    = colour_bus[8*player +: 8];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bg_addr     <= '0;
            sprite_addr <= '0;
            for (int i = 0; i <= ROM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= s1_nxt;
            if (pixel_valid) begin
                bg_addr <= cur_addr;
                if (s1_nxt.hit) begin
                    sprite_addr <= sprite_nxt;
                end
            end
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage.
    // ------------------------------------------------------------------
    logic [7:0] lane_px, index_nxt;

    assign out_d = pipe[ROM_LATENCY];

    always_comb begin
        lane_px = sprite_data[8*out_d.lane +: 8];
        if (out_d.indicator) begin
            index_nxt = out_d.colour;
        end else if (out_d.hit && (lane_px != TRANSPARENT)) begin
            index_nxt = lane_px;
        end else begin
            index_nxt = bg_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            index       <= '0;
            index_valid <= 1'b0;
        end else begin
            index_valid <= out_d.valid;
            if (out_d.valid) begin
                index <= index_nxt;
            end
        end
    end

endmodule
`default_nettype wire
